bcd_scan_driver: RTL and testbench

BCD_SCAN_DRIVER -- requirements
Module: bcd_scan_driver

---
 rtl/bcd_scan_driver_if.sv | 25 ++
 rtl/bcd_scan_driver.sv | 131 +++++++++++++
 tb/tb_bcd_scan_driver.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_driver_if.sv
// Bus bundle for the 4-digit scanned display peripheral.
// master drives strobes/address/data; slave returns Read_data.
interface bcd_scan_driver_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;

    modport master (
        output MemRead,
        output MemWrite,
        output Address,
        output Write_data,
        input  Read_data
    );

    modport slave (
        input  MemRead,
        input  MemWrite,
        input  Address,
        input  Write_data,
        output Read_data
    );
endinterface

// File: rtl/bcd_scan_driver.sv
// Memory-mapped 4-digit hex display scanner (VALUE @BASE_ADDR, CTRL @+4).
// Ports: clk, reset (async high), bus (slave), BCD_out[11:0]={anodes,segs}.
// Option: define BCD_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_scan_driver #(
    parameter int          SCAN_DIV  = 50000,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0014
) (
    input  logic                     clk,
    input  logic                     reset,
    bcd_scan_driver_if.slave         bus,
    output logic [11:0]              BCD_out
);

    localparam int          CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'd4;

    logic [15:0]   r_value;
    logic          r_en;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;

    logic          w_val_we;
    logic          w_ctl_we;
    logic          w_ctl_off;
    logic [3:0]    w_nib;
    logic [3:0]    w_an;
    logic [7:0]    w_seg_raw;
    logic [7:0]    w_seg;
    logic          w_unused_wdata;

    assign w_val_we  = bus.MemWrite && (bus.Address == BASE_ADDR);
    assign w_ctl_we  = bus.MemWrite && (bus.Address == CTRL_ADDR);
    assign w_ctl_off = w_ctl_we && !bus.Write_data[0];
    assign w_unused_wdata = ^bus.Write_data[31:16];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= 16'h0000;
            r_en    <= 1'b1;
        end else begin
            if (w_val_we)
                r_value <= bus.Write_data[15:0];
            if (w_ctl_we)
                r_en <= bus.Write_data[0];
        end
    end

    // Disabling clears the scan on the same edge, so a later
    // re-enable always starts from digit 0 with a fresh count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (!r_en || w_ctl_off) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        bus.Read_data = 32'h0;
        if (bus.MemRead) begin
            if (bus.Address == BASE_ADDR)
                bus.Read_data = {16'h0, r_value};
            else if (bus.Address == CTRL_ADDR)
                bus.Read_data = {28'h0, r_idx, 1'b0, r_en};
        end
    end

    always_comb begin
        w_nib = r_value[3:0];
        unique case (r_idx)
            2'd0: w_nib = r_value[3:0];
            2'd1: w_nib = r_value[7:4];
            2'd2: w_nib = r_value[11:8];
            2'd3: w_nib = r_value[15:12];
        endcase
    end

    always_comb begin
        w_seg_raw = 8'h00;
        unique case (w_nib)
            4'h0: w_seg_raw = 8'h3F;
            4'h1: w_seg_raw = 8'h06;
            4'h2: w_seg_raw = 8'h5B;
            4'h3: w_seg_raw = 8'h4F;
            4'h4: w_seg_raw = 8'h66;
            4'h5: w_seg_raw = 8'h6D;
            4'h6: w_seg_raw = 8'h7D;
            4'h7: w_seg_raw = 8'h07;
            4'h8: w_seg_raw = 8'h7F;
            4'h9: w_seg_raw = 8'h6F;
            4'hA: w_seg_raw = 8'h77;
            4'hB: w_seg_raw = 8'h7C;
            4'hC: w_seg_raw = 8'h39;
            4'hD: w_seg_raw = 8'h5E;
            4'hE: w_seg_raw = 8'h79;
            4'hF: w_seg_raw = 8'h71;
        endcase
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic w_blank;

    // A digit is a leading zero when it and every higher nibble
    // are zero; digit 0 always shows so zero reads as "0".
    always_comb begin
        w_blank = 1'b0;
        unique case (r_idx)
            2'd0: w_blank = 1'b0;
            2'd1: w_blank = (r_value[15:4] == 12'h000);
            2'd2: w_blank = (r_value[15:8] == 8'h00);
            2'd3: w_blank = (r_value[15:12] == 4'h0);
        endcase
    end

    assign w_seg = w_blank ? 8'h00 : w_seg_raw;
`else
    assign w_seg = w_seg_raw;
`endif

    assign w_an    = ~(4'b0001 << r_idx);
    assign BCD_out = r_en ? {w_an, w_seg} : 12'hF00;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Directed self-checking bench for bcd_scan_driver (SCAN_DIV=4).
// Works with or without BCD_LEADING_ZERO_BLANK_EN defined.
module tb_bcd_scan_driver;

    localparam logic [31:0] VAL_A = 32'h4000_0014;
    localparam logic [31:0] CTL_A = 32'h4000_0018;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam logic [11:0] D1_ZERO = 12'hD00;
    localparam logic [11:0] D2_ZERO = 12'hB00;
    localparam logic [11:0] D3_ZERO = 12'h700;
`else
    localparam logic [11:0] D1_ZERO = 12'hD3F;
    localparam logic [11:0] D2_ZERO = 12'hB3F;
    localparam logic [11:0] D3_ZERO = 12'h73F;
`endif

    logic        clk;
    logic        reset;
    logic [11:0] BCD_out;
    logic [31:0] rdat;
    int          total;
    int          bad;

    bcd_scan_driver_if bus();

    bcd_scan_driver #(
        .SCAN_DIV  (4),
        .BASE_ADDR (32'h4000_0014)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .BCD_out (BCD_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.Address    = a;
        bus.Write_data = d;
        bus.MemWrite   = 1'b1;
        @(posedge clk);
        #1;
        bus.MemWrite   = 1'b0;
        bus.Address    = 32'h0;
        bus.Write_data = 32'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.Address = a;
        bus.MemRead = 1'b1;
        #1;
        d = bus.Read_data;
        bus.MemRead = 1'b0;
        bus.Address = 32'h0;
    endtask

    logic [11:0] exp4 [4];

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.Address    = 32'h0;
        bus.Write_data = 32'h0;

        #1;
        check("rst_async", {20'h0, BCD_out}, 32'hE3F);
        tick(2);
        reset = 1'b0;
        check("rst_after", {20'h0, BCD_out}, 32'hE3F);
        rd(CTL_A, rdat);
        check("rst_ctrl", rdat, 32'h1);
        tick(3);
        check("dig0_hold", {20'h0, BCD_out}, 32'hE3F);
        tick(1);
        check("dig1_zero", {20'h0, BCD_out}, {20'h0, D1_ZERO});

        wr(CTL_A, 32'h0);
        wr(VAL_A, 32'hFFFF_12AB);
        wr(CTL_A, 32'h1);
        exp4[0] = 12'hE7C;
        exp4[1] = 12'hD77;
        exp4[2] = 12'hB5B;
        exp4[3] = 12'h706;
        for (int i = 0; i < 16; i++) begin
            check("scan_12ab", {20'h0, BCD_out}, {20'h0, exp4[i/4]});
            tick(1);
        end
        rd(VAL_A, rdat);
        check("rd_value", rdat, 32'h0000_12AB);

        tick(9);
        check("mid_dig2", {20'h0, BCD_out}, 32'hB5B);
        wr(CTL_A, 32'h0);
        check("off_next", {20'h0, BCD_out}, 32'hF00);
        rd(CTL_A, rdat);
        check("off_ctrl", rdat, 32'h0);
        tick(3);
        check("off_hold", {20'h0, BCD_out}, 32'hF00);
        wr(CTL_A, 32'h1);
        check("on_dig0", {20'h0, BCD_out}, 32'hE7C);
        rd(CTL_A, rdat);
        check("on_ctrl", rdat, 32'h1);
        tick(3);
        check("on_cnt3", {20'h0, BCD_out}, 32'hE7C);
        tick(1);
        check("on_dig1", {20'h0, BCD_out}, 32'hD77);

        tick(3);
        check("pre_coin", {20'h0, BCD_out}, 32'hD77);
        wr(VAL_A, 32'h0000_3CAB);
        check("coin_dig2", {20'h0, BCD_out}, 32'hB39);
        tick(4);
        check("coin_dig3", {20'h0, BCD_out}, 32'h74F);

        wr(CTL_A, 32'h0);
        wr(VAL_A, 32'h0000_0050);
        wr(CTL_A, 32'h1);
        exp4[0] = 12'hE3F;
        exp4[1] = 12'hD6D;
        exp4[2] = D2_ZERO;
        exp4[3] = D3_ZERO;
        for (int i = 0; i < 4; i++) begin
            check("blank_0050", {20'h0, BCD_out}, {20'h0, exp4[i]});
            tick(4);
        end

        rd(32'h4000_0010, rdat);
        check("rd_bad_lo", rdat, 32'h0);
        rd(32'h0000_0014, rdat);
        check("rd_bad_alias", rdat, 32'h0);
        bus.Address = VAL_A;
        #1;
        check("rd_no_strobe", bus.Read_data, 32'h0);
        bus.Address = 32'h0;
        wr(32'h0000_0014, 32'h0000_FFFF);
        wr(32'h4000_0010, 32'h0000_0000);
        wr(32'h4000_001C, 32'h0000_0000);
        rd(VAL_A, rdat);
        check("wr_bad_val", rdat, 32'h0000_0050);
        rd(CTL_A, rdat);
        check("wr_bad_en", rdat & 32'h1, 32'h1);

        tick(5);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid", {20'h0, BCD_out}, 32'hE3F);
        rd(VAL_A, rdat);
        check("rst_val", rdat, 32'h0);
        tick(2);
        reset = 1'b0;
        check("rst_rel", {20'h0, BCD_out}, 32'hE3F);
        tick(4);
        check("rst_dig1", {20'h0, BCD_out}, {20'h0, D1_ZERO});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
